muldiv_unit: RTL and testbench

//  Iterative multiply/divide unit with architectural HI/LO registers for the MIPS core.

---
 rtl/muldiv_unit_if.sv | 35 +++
 rtl/muldiv_unit.sv | 206 ++++++++++++++++++++
 tb/tb_muldiv_unit.sv | 374 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_unit_if
//  Description : Request/response bundle between the EX stage and the
//                iterative multiply/divide unit.
//  Revision    : 1.0 - initial release
// ============================================================================
interface muldiv_unit_if #(
    parameter int WIDTH = 32
);
    logic             req_valid;
    logic             req_ready;
    logic [1:0]       alu_op;
    logic [5:0]       funct;
    logic [WIDTH-1:0] rs_val;
    logic [WIDTH-1:0] rt_val;
    logic             kill;
    logic [WIDTH-1:0] rd_data;
    logic             busy;
    logic             done;
    logic             div_zero;

    // Pipeline side: issues requests, observes results
    modport master (
        output req_valid, alu_op, funct, rs_val, rt_val, kill,
        input  req_ready, rd_data, busy, done, div_zero
    );

    // Unit side
    modport slave (
        input  req_valid, alu_op, funct, rs_val, rt_val, kill,
        output req_ready, rd_data, busy, done, div_zero
    );
endinterface
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_unit
//  Description : Iterative MIPS multiply/divide unit with HI/LO registers.
//                Shift-add multiply retiring MUL_BPC bits per cycle,
//                restoring divide at one quotient bit per cycle, both on
//                operand magnitudes with a final sign-fix/commit cycle.
//                WIDTH must be even and >= 4; MUL_BPC in {1,2,4} dividing WIDTH.
//  Revision    : 1.0 - initial release
// ============================================================================
module muldiv_unit #(
    parameter int WIDTH   = 32,
    parameter int MUL_BPC = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    muldiv_unit_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    localparam int PW = WIDTH + MUL_BPC;
    localparam int DW = 2 * WIDTH;
    localparam logic [CW-1:0] c_MUL_LAST = CW'(WIDTH / MUL_BPC - 1);
    localparam logic [CW-1:0] c_DIV_LAST = CW'(WIDTH - 1);

    localparam logic [5:0] c_F_MULT  = 6'b011000;
    localparam logic [5:0] c_F_MULTU = 6'b011001;
    localparam logic [5:0] c_F_DIV   = 6'b011010;
    localparam logic [5:0] c_F_DIVU  = 6'b011011;
    localparam logic [5:0] c_F_MFHI  = 6'b010000;
    localparam logic [5:0] c_F_MTHI  = 6'b010001;
    localparam logic [5:0] c_F_MFLO  = 6'b010010;
    localparam logic [5:0] c_F_MTLO  = 6'b010011;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_FIX  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] hi_q, lo_q;
    // Working registers: MUL uses {work_hi,work_lo} as product/multiplier and
    // opb as multiplicand; DIV uses work_hi as remainder, work_lo as
    // dividend/quotient and opb as divisor.
    logic [WIDTH-1:0] work_hi_q, work_lo_q, opb_q;
    logic [CW-1:0]    cnt_q;
    logic             neg_quo_q, neg_rem_q, is_div_q, dz_q;
    logic             done_q, div_zero_q;

    // ---------------- request decode ----------------
    logic w_op, w_ready, w_mult, w_div, w_mthi, w_mtlo, w_mfhi, w_mflo;
    logic w_signed, w_accept, w_a_neg, w_b_neg, w_rt_zero;
    logic [WIDTH-1:0] w_a_mag, w_b_mag;

    assign w_op      = (bus.alu_op == 2'b10);
    assign w_ready   = (state_q == S_IDLE) && rst_n;
    assign w_mult    = w_op && (bus.funct == c_F_MULT || bus.funct == c_F_MULTU);
    assign w_div     = w_op && (bus.funct == c_F_DIV  || bus.funct == c_F_DIVU);
    assign w_mthi    = w_op && (bus.funct == c_F_MTHI);
    assign w_mtlo    = w_op && (bus.funct == c_F_MTLO);
    assign w_mfhi    = w_op && (bus.funct == c_F_MFHI);
    assign w_mflo    = w_op && (bus.funct == c_F_MFLO);
    // A kill arriving while idle suppresses the request presented alongside it
    assign w_accept  = bus.req_valid && w_ready && !bus.kill &&
                       (w_mult || w_div || w_mthi || w_mtlo || w_mfhi || w_mflo);
    assign w_signed  = (bus.funct == c_F_MULT) || (bus.funct == c_F_DIV);
    assign w_a_neg   = w_signed && bus.rs_val[WIDTH-1];
    assign w_b_neg   = w_signed && bus.rt_val[WIDTH-1];
    assign w_a_mag   = w_a_neg ? -bus.rs_val : bus.rs_val;
    assign w_b_mag   = w_b_neg ? -bus.rt_val : bus.rt_val;
    assign w_rt_zero = (bus.rt_val == '0);

    // ---------------- multiply step ----------------
    logic [PW-1:0] w_pp, w_sum;
    logic [DW-1:0] w_mul_next;
    assign w_pp       = PW'(opb_q) * PW'(work_lo_q[MUL_BPC-1:0]);
    assign w_sum      = PW'(work_hi_q) + w_pp;
    assign w_mul_next = DW'({w_sum, work_lo_q} >> MUL_BPC);

    // ---------------- divide step ----------------
    logic [WIDTH:0]   w_shift, w_diff;
    logic             w_ge;
    logic [WIDTH-1:0] w_rem_next;
    assign w_shift    = {work_hi_q, work_lo_q[WIDTH-1]};
    assign w_diff     = w_shift - {1'b0, opb_q};
    assign w_ge       = (w_shift >= {1'b0, opb_q});
    assign w_rem_next = WIDTH'(w_ge ? w_diff : w_shift);

    // ---------------- commit values ----------------
    logic [DW-1:0] w_prod, w_prod_fix;
    assign w_prod     = {work_hi_q, work_lo_q};
    assign w_prod_fix = neg_quo_q ? -w_prod : w_prod;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state: launch on accept, count iterations, kill aborts anywhere
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (w_accept && w_mult)      state_d = S_MUL;
                else if (w_accept && w_div)  state_d = w_rt_zero ? S_FIX : S_DIV;
            end
            S_MUL:   if (cnt_q == '0) state_d = S_FIX;
            S_DIV:   if (cnt_q == '0) state_d = S_FIX;
            S_FIX:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (bus.kill) state_d = S_IDLE;
    end

    // Datapath: operand capture, iteration, HI/LO commit and result pulses
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hi_q       <= '0;
            lo_q       <= '0;
            work_hi_q  <= '0;
            work_lo_q  <= '0;
            opb_q      <= '0;
            cnt_q      <= '0;
            neg_quo_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            is_div_q   <= 1'b0;
            dz_q       <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (w_accept && w_mthi) hi_q <= bus.rs_val;
                    if (w_accept && w_mtlo) lo_q <= bus.rs_val;
                    if (w_accept && w_mult) begin
                        opb_q     <= w_a_mag;
                        work_hi_q <= '0;
                        work_lo_q <= w_b_mag;
                        neg_quo_q <= w_a_neg ^ w_b_neg;
                        neg_rem_q <= 1'b0;
                        is_div_q  <= 1'b0;
                        dz_q      <= 1'b0;
                        cnt_q     <= c_MUL_LAST;
                    end
                    if (w_accept && w_div) begin
                        is_div_q <= 1'b1;
                        dz_q     <= w_rt_zero;
                        cnt_q    <= c_DIV_LAST;
                        opb_q    <= w_b_mag;
                        if (w_rt_zero) begin
                            // Result is preloaded; FIX commits it unmodified
                            work_hi_q <= bus.rs_val;
                            work_lo_q <= '1;
                            neg_quo_q <= 1'b0;
                            neg_rem_q <= 1'b0;
                        end else begin
                            work_hi_q <= '0;
                            work_lo_q <= w_a_mag;
                            neg_quo_q <= w_a_neg ^ w_b_neg;
                            neg_rem_q <= w_a_neg;
                        end
                    end
                end
                S_MUL: begin
                    {work_hi_q, work_lo_q} <= w_mul_next;
                    cnt_q <= cnt_q - CW'(1);
                end
                S_DIV: begin
                    work_hi_q <= w_rem_next;
                    work_lo_q <= {work_lo_q[WIDTH-2:0], w_ge};
                    cnt_q     <= cnt_q - CW'(1);
                end
                S_FIX: begin
                    if (!bus.kill) begin
                        if (is_div_q) begin
                            lo_q <= neg_quo_q ? -work_lo_q : work_lo_q;
                            hi_q <= neg_rem_q ? -work_hi_q : work_hi_q;
                        end else begin
                            {hi_q, lo_q} <= w_prod_fix;
                        end
                        done_q     <= 1'b1;
                        div_zero_q <= dz_q;
                    end
                end
                default: ;
            endcase
        end
    end

    // Output read mux for MFHI/MFLO
    always_comb begin
        bus.rd_data = '0;
        if (w_mfhi)      bus.rd_data = hi_q;
        else if (w_mflo) bus.rd_data = lo_q;
    end

    assign bus.req_ready = w_ready;
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.done      = done_q;
    assign bus.div_zero  = div_zero_q;
endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_muldiv_unit
//  Description : Self-checking bench for muldiv_unit. Two instances
//                (MUL_BPC=1 and MUL_BPC=4) share one stimulus stream; each
//                has its own scoreboard of expected HI/LO/div_zero/latency.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;
    localparam int W = 32;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req_valid = 1'b0;
    logic [1:0]   alu_op = 2'b10;
    logic [5:0]   funct = F_MFHI;
    logic [W-1:0] rs_val = '0;
    logic [W-1:0] rt_val = '0;
    logic         kill = 1'b0;

    muldiv_unit_if #(.WIDTH(W)) bus1 ();
    muldiv_unit_if #(.WIDTH(W)) bus4 ();

    assign bus1.req_valid = req_valid;
    assign bus1.alu_op    = alu_op;
    assign bus1.funct     = funct;
    assign bus1.rs_val    = rs_val;
    assign bus1.rt_val    = rt_val;
    assign bus1.kill      = kill;
    assign bus4.req_valid = req_valid;
    assign bus4.alu_op    = alu_op;
    assign bus4.funct     = funct;
    assign bus4.rs_val    = rs_val;
    assign bus4.rt_val    = rt_val;
    assign bus4.kill      = kill;

    muldiv_unit #(.WIDTH(W), .MUL_BPC(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));
    muldiv_unit #(.WIDTH(W), .MUL_BPC(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4.slave));

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
        int           lat;
    } exp_t;

    typedef struct {
        logic [5:0]   f;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
    } vec_t;

    exp_t sb1[$];
    exp_t sb4[$];
    vec_t tbl[14];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: event did not occur within cycle budget", name);
    endtask

    function automatic int lat_of(input logic [5:0] f, input logic [W-1:0] b, input int bpc);
        if (f == F_MULT || f == F_MULTU) return W / bpc + 1;
        if (b == '0) return 1;
        return W + 1;
    endfunction

    // Reference arithmetic for the randomised vectors
    task automatic model(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] hi, output logic [W-1:0] lo, output logic dz);
        longint      p;
        logic [63:0] u;
        dz = 1'b0; hi = '0; lo = '0;
        if (f == F_MULT) begin
            p = longint'($signed(a)) * longint'($signed(b));
            u = p;
            hi = u[63:32]; lo = u[31:0];
        end else if (f == F_MULTU) begin
            u = {32'b0, a} * {32'b0, b};
            hi = u[63:32]; lo = u[31:0];
        end else if (b == '0) begin
            dz = 1'b1; lo = '1; hi = a;
        end else if (f == F_DIV) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                lo = a; hi = '0;
            end else begin
                lo = $signed(a) / $signed(b);
                hi = $signed(a) % $signed(b);
            end
        end else begin
            lo = a / b;
            hi = a % b;
        end
    endtask

    // Read HI and LO of both instances via MFHI/MFLO (combinational path)
    task automatic read_check(input string tag, input logic [W-1:0] hi, input logic [W-1:0] lo);
        @(negedge clk);
        req_valid = 1'b0; alu_op = 2'b10; funct = F_MFHI;
        #1;
        check({tag, "_hi"}, {bus1.rd_data, bus4.rd_data}, {hi, hi});
        funct = F_MFLO;
        #1;
        check({tag, "_lo"}, {bus1.rd_data, bus4.rd_data}, {lo, lo});
        funct = F_MFHI;
    endtask

    task automatic mt(input logic [5:0] f, input logic [W-1:0] v);
        @(posedge clk); #1;
        req_valid = 1'b1; funct = f; rs_val = v;
        @(posedge clk); #1;
        req_valid = 1'b0; funct = F_MFHI;
        @(negedge clk);
        check("mt_nodone", {bus1.done, bus4.done}, 2'b00);
    endtask

    // Issue one MULT/DIV, then wait for each instance's done and score it
    task automatic run_op(input string tag, input logic [5:0] f, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] hi,
                          input logic [W-1:0] lo, input logic dz);
        exp_t e, x;
        int   k;
        bit   got1, got4, d1, d4;
        e.hi = hi; e.lo = lo; e.dz = dz;
        e.lat = lat_of(f, b, 1); sb1.push_back(e);
        e.lat = lat_of(f, b, 4); sb4.push_back(e);
        @(posedge clk); #1;
        req_valid = 1'b1; alu_op = 2'b10; funct = f; rs_val = a; rt_val = b;
        @(negedge clk);
        check({tag, "_ready"}, {bus1.req_ready, bus4.req_ready}, 2'b11);
        @(posedge clk); #1;
        // Scramble operands: the unit must use the values captured on accept
        req_valid = 1'b0; funct = F_MFHI; rs_val = $urandom; rt_val = $urandom;
        k = 0; got1 = 0; got4 = 0;
        while (!(got1 && got4) && k < 100) begin
            @(posedge clk); k++;
            @(negedge clk);
            if (k == 1)
                check({tag, "_busy"}, {bus1.busy, bus4.busy},
                      {lat_of(f, b, 1) > 1, lat_of(f, b, 4) > 1});
            d1 = bus1.done && !got1;
            d4 = bus4.done && !got4;
            if (d1) begin
                got1 = 1;
                if (sb1.size() == 0) fail_now({tag, "_sb1_empty"});
                else begin
                    x = sb1.pop_front();
                    check({tag, "_lat1"}, k, x.lat);
                    check({tag, "_dz1"}, bus1.div_zero, x.dz);
                    check({tag, "_hi1"}, bus1.rd_data, x.hi);
                    e = x;
                end
            end
            if (d4) begin
                got4 = 1;
                if (sb4.size() == 0) fail_now({tag, "_sb4_empty"});
                else begin
                    x = sb4.pop_front();
                    check({tag, "_lat4"}, k, x.lat);
                    check({tag, "_dz4"}, bus4.div_zero, x.dz);
                    check({tag, "_hi4"}, bus4.rd_data, x.hi);
                end
            end
            if (d1 || d4) begin
                funct = F_MFLO;
                #1;
                if (d1) check({tag, "_lo1"}, bus1.rd_data, lo);
                if (d4) check({tag, "_lo4"}, bus4.rd_data, lo);
                funct = F_MFHI;
            end
        end
        if (!got1) fail_now({tag, "_done1_timeout"});
        if (!got4) fail_now({tag, "_done4_timeout"});
        @(negedge clk);
        check({tag, "_pulse"}, {bus1.done, bus4.done, bus1.div_zero, bus4.div_zero}, 4'b0000);
    endtask

    initial begin
        int           k, ndone;
        bit           g1, g4;
        logic [5:0]   rf;
        logic [W-1:0] ra, rb, mh, ml;
        logic         mdz;

        tbl[0]  = '{F_MULT,  32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0};
        tbl[1]  = '{F_MULTU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
        tbl[2]  = '{F_MULT,  32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0};
        tbl[3]  = '{F_MULT,  32'hFFFF_FFFF,  32'd1,         32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0};
        tbl[4]  = '{F_MULTU, 32'h0001_0000,  32'h0001_0000, 32'h0000_0001, 32'h0000_0000, 1'b0};
        tbl[5]  = '{F_DIV,   32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
        tbl[6]  = '{F_DIV,   32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
        tbl[7]  = '{F_DIVU,  32'h0000_1234,  32'd0,         32'h0000_1234, 32'hFFFF_FFFF, 1'b1};
        tbl[8]  = '{F_DIV,   32'd7,          32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0};
        tbl[9]  = '{F_DIVU,  32'hFFFF_FFFF,  32'h10,        32'h0000_000F, 32'h0FFF_FFFF, 1'b0};
        tbl[10] = '{F_DIV,   32'd5,          32'd0,         32'h0000_0005, 32'hFFFF_FFFF, 1'b1};
        tbl[11] = '{F_DIV,   32'hFFFF_FF9C,  32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFF2, 1'b0};
        tbl[12] = '{F_DIVU,  32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000, 1'b0};
        tbl[13] = '{F_DIV,   32'hFFFF_FFFF,  32'd0,         32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1};

        // Reset
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready_low", {bus1.req_ready, bus4.req_ready}, 2'b00);
        check("rst_outputs", {bus1.busy, bus4.busy, bus1.done, bus4.done,
                              bus1.div_zero, bus4.div_zero}, 6'b0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_ready_high", {bus1.req_ready, bus4.req_ready}, 2'b11);
        read_check("rst", '0, '0);

        // MTHI / MTLO
        mt(F_MTHI, 32'hAAAA_5555);
        mt(F_MTLO, 32'h1234_5678);
        read_check("mt", 32'hAAAA_5555, 32'h1234_5678);

        // Table-driven MULT/DIV vectors
        for (int i = 0; i < 14; i++)
            run_op($sformatf("v%0d", i), tbl[i].f, tbl[i].a, tbl[i].b,
                   tbl[i].hi, tbl[i].lo, tbl[i].dz);

        // Kill mid-operation: HI/LO untouched, no done, ready next cycle
        mt(F_MTLO, 32'd5);
        mt(F_MTHI, 32'd6);
        @(posedge clk); #1;
        req_valid = 1'b1; funct = F_MULT; rs_val = 32'd3; rt_val = 32'd4;
        @(posedge clk); #1;
        req_valid = 1'b0; funct = F_MFHI;
        repeat (4) @(posedge clk);
        #1 kill = 1'b1;
        @(posedge clk); #1 kill = 1'b0;
        @(negedge clk);
        check("kill_busy", {bus1.busy, bus4.busy}, 2'b00);
        check("kill_ready", {bus1.req_ready, bus4.req_ready}, 2'b11);
        ndone = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus1.done || bus4.done) ndone++;
        end
        check("kill_nodone", ndone, 0);
        read_check("kill", 32'd6, 32'd5);

        // Kill while idle blocks the accompanying MTLO
        @(posedge clk); #1;
        kill = 1'b1; req_valid = 1'b1; funct = F_MTLO; rs_val = 32'd77;
        @(posedge clk); #1;
        kill = 1'b0; req_valid = 1'b0; funct = F_MFHI;
        read_check("kill_idle", 32'd6, 32'd5);

        // Kill coinciding with the FIX commit wins
        @(posedge clk); #1;
        req_valid = 1'b1; funct = F_DIVU; rs_val = 32'd9; rt_val = 32'd0;
        @(posedge clk); #1;
        req_valid = 1'b0; funct = F_MFHI; kill = 1'b1;
        @(posedge clk); #1 kill = 1'b0;
        @(negedge clk);
        check("kill_fix_flags", {bus1.done, bus4.done, bus1.div_zero, bus4.div_zero,
                                 bus1.busy, bus4.busy}, 6'b0);
        read_check("kill_fix", 32'd6, 32'd5);

        // Back-to-back: next request accepted in the done cycle
        @(posedge clk); #1;
        req_valid = 1'b1; funct = F_DIV; rs_val = 32'd100; rt_val = 32'd7;
        @(posedge clk); #1;
        req_valid = 1'b0; funct = F_MFHI;
        k = 0;
        do begin
            @(negedge clk); k++;
        end while (!bus1.done && k < 100);
        check("b2b_done", {bus1.done, bus4.done}, 2'b11);
        check("b2b_ready", {bus1.req_ready, bus4.req_ready}, 2'b11);
        check("b2b_hi", {bus1.rd_data, bus4.rd_data}, {32'd2, 32'd2});
        req_valid = 1'b1; funct = F_DIVU; rs_val = 32'd9; rt_val = 32'd0;
        @(posedge clk); #1;
        req_valid = 1'b0; funct = F_MFHI;
        @(negedge clk);
        check("b2b_busy", {bus1.busy, bus4.busy, bus1.done, bus4.done}, 4'b1100);
        @(negedge clk);
        check("b2b_dz", {bus1.done, bus4.done, bus1.div_zero, bus4.div_zero}, 4'b1111);
        check("b2b_hi2", {bus1.rd_data, bus4.rd_data}, {32'd9, 32'd9});
        funct = F_MFLO;
        #1;
        check("b2b_lo2", {bus1.rd_data, bus4.rd_data}, {32'hFFFF_FFFF, 32'hFFFF_FFFF});
        funct = F_MFHI;

        // MFHI presented while busy: stalled until the done cycle
        @(posedge clk); #1;
        req_valid = 1'b1; funct = F_MULTU; rs_val = 32'h0001_0000; rt_val = 32'h0003_0000;
        @(posedge clk); #1;
        funct = F_MFHI;
        @(posedge clk);
        @(negedge clk);
        check("mfhi_busy_ready", {bus1.req_ready, bus4.req_ready}, 2'b00);
        k = 0; g1 = 0; g4 = 0;
        while (!(g1 && g4) && k < 100) begin
            @(negedge clk); k++;
            if (bus4.done && !g4) begin
                g4 = 1;
                check("mfhi_ready4", {bus4.req_ready, bus1.req_ready}, 2'b10);
                check("mfhi_rd4", bus4.rd_data, 32'd3);
            end
            if (bus1.done && !g1) begin
                g1 = 1;
                check("mfhi_ready1", bus1.req_ready, 1'b1);
                check("mfhi_rd1", bus1.rd_data, 32'd3);
            end
        end
        if (!g1) fail_now("mfhi_done1_timeout");
        if (!g4) fail_now("mfhi_done4_timeout");
        req_valid = 1'b0;

        // Reset mid-operation discards everything
        @(posedge clk); #1;
        req_valid = 1'b1; funct = F_MULT; rs_val = 32'd5; rt_val = 32'd5;
        @(posedge clk); #1;
        req_valid = 1'b0; funct = F_MFHI;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        check("midrst_ready_low", {bus1.req_ready, bus4.req_ready, bus1.busy, bus4.busy}, 4'b0011);
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        check("midrst_idle", {bus1.req_ready, bus4.req_ready, bus1.busy, bus4.busy}, 4'b1100);
        ndone = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus1.done || bus4.done) ndone++;
        end
        check("midrst_nodone", ndone, 0);
        read_check("midrst", '0, '0);

        // Randomised operations scored against the reference model
        for (int i = 0; i < 10; i++) begin
            case ($urandom_range(0, 3))
                0:       rf = F_MULT;
                1:       rf = F_MULTU;
                2:       rf = F_DIV;
                default: rf = F_DIVU;
            endcase
            ra = $urandom;
            rb = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom >> $urandom_range(0, 28));
            model(rf, ra, rb, mh, ml, mdz);
            run_op($sformatf("r%0d", i), rf, ra, rb, mh, ml, mdz);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
